// File: rtl/regfile_wb_arbiter_if.sv
// Register-file writeback bus between the writeback sources and the arbiter.
//   pipe_valid/pipe_rd/pipe_data : in-order WB stage result; pipe_stall holds it
//   mc_valid/mc_rd/mc_data       : multi-cycle unit result; mc_ready consumes it
//   rf_we/rf_waddr/rf_wdata      : registered register-file write port (also forwarding tap)
// master: the side producing results and observing the RF port; slave: the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   logic              pipe_valid;
   logic [REG_AW-1:0] pipe_rd;
   logic [XLEN-1:0]   pipe_data;
   logic              pipe_stall;
   logic              mc_valid;
   logic [REG_AW-1:0] mc_rd;
   logic [XLEN-1:0]   mc_data;
   logic              mc_ready;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;

   modport master (
      output pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
      input  pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
      output pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage
// (priority) and a multi-cycle unit. After STARVE_LIMIT consecutive refused mc
// cycles, one cycle is spent in a forced mode that grants mc and stalls WB.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous reset, active-high
//   wb  : writeback bus (slave modport); pipe_stall/mc_ready are combinational,
//         rf_we/rf_waddr/rf_wdata are registered (RF writes on negedge of that cycle)
module regfile_wb_arbiter #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave wb
);
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
   localparam logic [CntW-1:0] CntArm = CntW'(STARVE_LIMIT - 1);

   typedef enum logic [0:0] {StPipePri, StMcForce} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

   logic pipe_w, mc_w;
   logic pipe_stall_c, mc_ready_c;
   logic sel_pipe, sel_mc;

   always_comb begin
      // rd==0 results are consumed without ever claiming the port.
      pipe_w       = wb.pipe_valid && (wb.pipe_rd != '0);
      mc_w         = wb.mc_valid && (wb.mc_rd != '0);
      pipe_stall_c = 1'b0;
      mc_ready_c   = 1'b0;
      sel_pipe     = 1'b0;
      sel_mc       = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StPipePri: begin
               mc_ready_c = wb.mc_valid && !pipe_w;
               sel_pipe   = pipe_w;
               sel_mc     = !pipe_w && mc_w;
            end
            StMcForce: begin
               mc_ready_c   = wb.mc_valid;
               pipe_stall_c = pipe_w;
               sel_mc       = mc_w;
            end
            default: ;
         endcase
      end

      rf_we_d    = sel_pipe || sel_mc;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (sel_pipe) begin
         rf_waddr_d = wb.pipe_rd;
         rf_wdata_d = wb.pipe_data;
      end else if (sel_mc) begin
         rf_waddr_d = wb.mc_rd;
         rf_wdata_d = wb.mc_data;
      end

      if (wb.mc_valid && !mc_ready_c) begin
         cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      end else begin
         cnt_d = '0;
      end

      state_d = state_q;
      unique case (state_q)
         StPipePri: begin
            if (wb.mc_valid && !mc_ready_c && cnt_q == CntArm) state_d = StMcForce;
         end
         // Forced mode lasts exactly one cycle whether or not mc handshakes.
         StMcForce: state_d = StPipePri;
         default:   state_d = StPipePri;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StPipePri;
         cnt_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign wb.pipe_stall = pipe_stall_c;
   assign wb.mc_ready   = mc_ready_c;
   assign wb.rf_we      = rf_we_q;
   assign wb.rf_waddr   = rf_waddr_q;
   assign wb.rf_wdata   = rf_wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

   regfile_wb_arbiter #(.XLEN(32), .REG_AW(5), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pipe_valid = 1'b0;
      bus.pipe_rd    = '0;
      bus.pipe_data  = '0;
      bus.mc_valid   = 1'b0;
      bus.mc_rd      = '0;
      bus.mc_data    = '0;
   endtask

   // Model: pipeline wins unless mc has already been refused LIMIT cycles in a row,
   // in which case mc is granted and a writing pipe result is stalled. The write
   // chosen in a cycle appears on the RF port one cycle later.
   logic        m_known = 1'b0;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_wait = 0;
   logic        c_pw, c_mw, c_forced, c_ready, c_stall, c_wp, c_wm;

   always @(negedge clk) begin
      if (m_known) begin
         check("rf_we", bus.rf_we, m_we);
         check("rf_waddr", bus.rf_waddr, m_waddr);
         check("rf_wdata", bus.rf_wdata, m_wdata);
         if (bus.rf_we) check("rf_waddr_nonzero", bus.rf_waddr != 5'd0, 1'b1);
      end
      if (rst) begin
         check("rst_mc_ready", bus.mc_ready, 1'b0);
         check("rst_pipe_stall", bus.pipe_stall, 1'b0);
         m_we    = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
         m_wait  = 0;
         m_known = 1'b1;
      end else begin
         c_pw     = bus.pipe_valid && bus.pipe_rd != 5'd0;
         c_mw     = bus.mc_valid && bus.mc_rd != 5'd0;
         c_forced = m_wait >= LIMIT;
         c_ready  = bus.mc_valid && (c_forced || !c_pw);
         c_stall  = c_forced && c_pw;
         check("mc_ready", bus.mc_ready, c_ready);
         check("pipe_stall", bus.pipe_stall, c_stall);
         if (bus.mc_valid) check("mc_wait_bound", m_wait <= LIMIT, 1'b1);
         c_wp = !c_forced && c_pw;
         c_wm = c_mw && c_ready;
         m_we = c_wp || c_wm;
         if (c_wp) begin
            m_waddr = bus.pipe_rd;
            m_wdata = bus.pipe_data;
         end else if (c_wm) begin
            m_waddr = bus.mc_rd;
            m_wdata = bus.mc_data;
         end
         m_wait = (bus.mc_valid && !c_ready) ? m_wait + 1 : 0;
      end
   end

   logic prev_stall, prev_ready;

   initial begin
      idle();
      repeat (3) cyc();
      check("reset_rf_we", bus.rf_we, 1'b0);
      check("reset_rf_waddr", bus.rf_waddr, 5'd0);
      check("reset_rf_wdata", bus.rf_wdata, 32'd0);
      rst = 1'b0;
      cyc();

      // Plain pipeline write.
      bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
      #1 check("t1_stall", bus.pipe_stall, 1'b0);
      cyc();
      idle();
      check("t1_we", bus.rf_we, 1'b1);
      check("t1_waddr", bus.rf_waddr, 5'd5);
      check("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
      cyc();

      // Starvation: mc granted on its 5th valid cycle, then the held pipe result.
      bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'hCAFE0003;
      bus.mc_valid   = 1'b1; bus.mc_rd   = 5'd9; bus.mc_data   = 32'h1234;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check("t2_ready", bus.mc_ready, k == 5);
         check("t2_stall", bus.pipe_stall, k == 5);
         @(posedge clk);
         #1;
      end
      bus.mc_valid = 1'b0;
      check("t2_mc_we", bus.rf_we, 1'b1);
      check("t2_mc_waddr", bus.rf_waddr, 5'd9);
      check("t2_mc_wdata", bus.rf_wdata, 32'h1234);
      cyc();
      bus.pipe_valid = 1'b0;
      check("t2_pipe_waddr", bus.rf_waddr, 5'd3);
      check("t2_pipe_wdata", bus.rf_wdata, 32'hCAFE0003);
      cyc();
      check("t2_idle_we", bus.rf_we, 1'b0);
      check("t2_hold_waddr", bus.rf_waddr, 5'd3);

      // Pipe rd=0 does not block mc.
      bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h77;
      bus.mc_valid   = 1'b1; bus.mc_rd   = 5'd7; bus.mc_data   = 32'h55;
      #1;
      check("t3_ready", bus.mc_ready, 1'b1);
      check("t3_stall", bus.pipe_stall, 1'b0);
      cyc();
      idle();
      check("t3_we", bus.rf_we, 1'b1);
      check("t3_waddr", bus.rf_waddr, 5'd7);
      check("t3_wdata", bus.rf_wdata, 32'h55);
      cyc();
      check("t3_after_we", bus.rf_we, 1'b0);

      // mc rd=0 consumed without a write.
      bus.mc_valid = 1'b1; bus.mc_rd = 5'd0; bus.mc_data = 32'h99;
      #1 check("t4_ready", bus.mc_ready, 1'b1);
      cyc();
      idle();
      check("t4_we", bus.rf_we, 1'b0);
      cyc();

      // Reset during the forced cycle.
      bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'hA3;
      bus.mc_valid   = 1'b1; bus.mc_rd   = 5'd9; bus.mc_data   = 32'hB9;
      repeat (4) cyc();
      rst = 1'b1;
      #1;
      check("t5_ready", bus.mc_ready, 1'b0);
      check("t5_stall", bus.pipe_stall, 1'b0);
      cyc();
      rst = 1'b0;
      check("t5_we", bus.rf_we, 1'b0);
      check("t5_waddr", bus.rf_waddr, 5'd0);
      #1 check("t5_restart_ready", bus.mc_ready, 1'b0);
      cyc();
      idle();
      cyc();

      // mc_valid dropped in the forced cycle: no write, pipe stalled once.
      bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd4; bus.pipe_data = 32'hC4;
      bus.mc_valid   = 1'b1; bus.mc_rd   = 5'd10; bus.mc_data  = 32'hDA;
      repeat (4) cyc();
      bus.mc_valid = 1'b0;
      #1 check("t6_stall", bus.pipe_stall, 1'b1);
      cyc();
      check("t6_we", bus.rf_we, 1'b0);
      cyc();
      bus.pipe_valid = 1'b0;
      check("t6_pipe_waddr", bus.rf_waddr, 5'd4);
      cyc();

      // Mixed traffic obeying the hold protocols; checked by the model.
      prev_stall = 1'b0;
      prev_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!prev_stall) begin
            bus.pipe_valid = (i % 3) != 1;
            bus.pipe_rd    = 5'((i * 7) % 32);
            bus.pipe_data  = 32'h1000_0000 + 32'(i);
         end
         if (!bus.mc_valid || prev_ready) begin
            bus.mc_valid = (i % 4) != 3;
            bus.mc_rd    = 5'((i * 5 + 1) % 32);
            bus.mc_data  = 32'h2000_0000 + 32'(i);
         end
         #1;
         prev_stall = bus.pipe_stall;
         prev_ready = bus.mc_ready;
         @(posedge clk);
         #1;
      end
      idle();
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
